ps2_keyboard: RTL
=================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive equal samples needed to accept a ps2_clk level change.
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000: clk cycles without a filtered falling edge, mid-frame, before the frame is aborted.
REQ-003 SHALL have parameter DEPTH, default 4: key FIFO entries; must be a power of two, 2..16.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port ps2_clk, input, 1 bit: keyboard clock; asynchronous to clk.
REQ-007 SHALL have port ps2_data, input, 1 bit: keyboard data; asynchronous to clk.
REQ-008 SHALL have port key_get, input, 1 bit: consumer acknowledge; pops the FIFO head.
REQ-009 SHALL have port key_down, output, 1 bit: high while the FIFO is non-empty.
REQ-010 SHALL have port spec_key, output, 8 bits: FIFO head code; 8'h00 when the FIFO is empty.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a parity, stop or timeout error.
REQ-012 SHALL have port overflow, output, 1 bit: sticky; set when a key is dropped because the FIFO is full.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through two-flop synchronizers.
REQ-014 SHALL update the filtered clock only after FILTER_LEN consecutive equal synchronized samples.
REQ-015 SHALL sample the synchronized ps2_data once per filtered-clock falling edge (1->0).
REQ-016 SHALL run frame FSM states IDLE, DATA, PARITY, STOP.
- IDLE->DATA when the sampled bit is 0; a sampled 1 stays in IDLE.
- DATA captures 8 bits LSB first, using a 3-bit counter, then goes to PARITY.
- PARITY->STOP.
- STOP->IDLE.
REQ-017 SHALL accept a frame only if the parity is odd (data bits XOR parity bit = 1) and the stop bit is 1; otherwise SHALL pulse frame_err, discard the byte and return to IDLE.
REQ-018 SHALL count clk cycles in any state other than IDLE and clear the count on each filtered falling edge.
REQ-019 SHALL, when the count reaches TIMEOUT, pulse frame_err, discard the partial frame and go to IDLE.
REQ-020 SHALL deliver each accepted byte to the decoder FSM one cycle after the STOP sample. Decoder states are NORM, EXT, BRK, EXTBRK.
- NORM: 8'hE0 -> EXT; 8'hF0 -> BRK; 8'hAA and 8'hFA are ignored; any other byte is pushed as-is.
- EXT: 8'hF0 -> EXTBRK; any other byte is pushed as byte|8'h80, then -> NORM.
- BRK and EXTBRK: the next byte is discarded (key release), then -> NORM.
REQ-021 SHALL register key_get and pop exactly once per 0->1 transition of the registered value; holding key_get high pops nothing further.
REQ-022 SHALL update key_down and spec_key in the cycle after a push or pop, with no other latency.
REQ-023 SHALL, on a push into a full FIFO, drop the new code, keep the stored codes unchanged and set overflow.
REQ-024 SHALL ignore a pop request while the FIFO is empty.
REQ-025 SHALL, on a simultaneous push and pop:
- non-empty FIFO: perform both, count unchanged, the head advances;
- full FIFO: perform both, no drop, overflow not set.
REQ-026 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-027 SHALL clear overflow only on reset.

Reset
REQ-028 SHALL, while rst is high, force: frame FSM IDLE; decoder NORM; FIFO empty; key_down=0; spec_key=8'h00; frame_err=0; overflow=0; synchronizers and filtered clock at 1; counters at 0.
REQ-029 SHALL, when rst asserts mid-frame, discard the partial frame; after release, the first accepted frame SHALL start at a fresh start bit.

Verification
REQ-030 SHALL cover make code: frame 8'h1C with parity 0 -> key_down=1, spec_key=8'h1C; then a key_get 0->1 pulse -> key_down=0, spec_key=8'h00.
REQ-031 SHALL cover break and extended codes: bytes F0,1C -> no push; bytes E0,75 -> spec_key=8'hF5; bytes E0,F0,75 -> no push.
REQ-032 SHALL cover a bad frame: 8'h1C with parity 1 -> one frame_err pulse, no push; a following good 8'h32 -> spec_key=8'h32.
REQ-033 SHALL cover timeout: stop ps2_clk after 4 data bits -> frame_err pulse TIMEOUT cycles after the last edge; a following good 8'h1B -> pushed.
REQ-034 SHALL cover overflow with DEPTH=4: push 8'h15,1D,24,2D,2C -> overflow=1; four pops yield 15,1D,24,2D, then key_down=0.
REQ-035 SHALL cover glitch and reset: a ps2_clk glitch shorter than FILTER_LEN is ignored; rst asserted mid-frame, then a full frame 8'h1C -> exactly one push of 8'h1C.

Source files
------------

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard receiver with scan-code decoder and key FIFO
module ps2_keyboard #(
  parameter int          FILTER_LEN = 8,
  parameter logic [15:0] TIMEOUT    = 16'd50000,
  parameter int          DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_get,
  output logic       key_down,
  output logic [7:0] spec_key,
  output logic       frame_err,
  output logic       overflow
);

  localparam int             FW       = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0]  FLT_LAST = FW'(FILTER_LEN - 1);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
  typedef enum logic [1:0] {D_NORM, D_EXT, D_BRK, D_EXTBRK} dec_state_t;

  // synchronizers
  logic clk_s1, clk_s2, data_s1, data_s2;

  // glitch filter
  logic [FW-1:0] flt_cnt;
  logic          fclk;
  logic          flt_flip;
  logic          fall;

  // frame receiver
  frame_state_t frame_state, frame_next;
  logic [2:0]   bit_cnt;
  logic [7:0]   shreg;
  logic         par_bit;
  logic [15:0]  tcnt;
  logic         timeout_hit;
  logic         frame_ok;
  logic         frame_bad;
  logic         rx_valid;
  logic [7:0]   rx_byte;

  // decoder
  dec_state_t dec_state, dec_next;
  logic       push;
  logic [7:0] push_code;

  // consumer handshake and FIFO
  logic          key_get_q, key_get_q2;
  logic          pop_req;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty, fifo_full;
  logic          do_push, do_pop;

  // Two-flop synchronizers for both keyboard lines; idle level of the bus is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  assign flt_flip = (clk_s2 != fclk) && (flt_cnt == FLT_LAST);
  assign fall     = flt_flip && fclk;

  // Glitch filter: any sample equal to the current filtered level restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fclk    <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s2 == fclk) begin
      flt_cnt <= '0;
    end else if (flt_flip) begin
      fclk    <= clk_s2;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // A stalled frame is abandoned once TIMEOUT cycles pass without a falling edge.
  assign timeout_hit = (frame_state != F_IDLE) && !fall && (tcnt == TIMEOUT - 16'd1);

  // Frame FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_state <= F_IDLE;
    else     frame_state <= frame_next;
  end

  // Frame FSM next state; the stop sample decides accept versus error.
  always_comb begin
    frame_next = frame_state;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    if (timeout_hit) begin
      frame_next = F_IDLE;
      frame_bad  = 1'b1;
    end else if (fall) begin
      case (frame_state)
        F_IDLE:   if (!data_s2) frame_next = F_DATA;
        F_DATA:   if (bit_cnt == 3'd7) frame_next = F_PARITY;
        F_PARITY: frame_next = F_STOP;
        F_STOP: begin
          frame_next = F_IDLE;
          if (((^shreg) ^ par_bit) && data_s2) frame_ok  = 1'b1;
          else                                 frame_bad = 1'b1;
        end
        default:  frame_next = F_IDLE;
      endcase
    end
  end

  // Frame datapath: bit shifting LSB first, parity capture and the stall timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_bit <= 1'b0;
      tcnt    <= 16'd0;
    end else begin
      if (frame_state == F_IDLE || fall) tcnt <= 16'd0;
      else                               tcnt <= tcnt + 16'd1;
      if (fall) begin
        case (frame_state)
          F_IDLE: bit_cnt <= 3'd0;
          F_DATA: begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          F_PARITY: par_bit <= data_s2;
          default: ;
        endcase
      end
    end
  end

  // Accepted bytes reach the decoder one cycle after the stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid  <= 1'b0;
      rx_byte   <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= frame_ok;
      rx_byte   <= shreg;
      frame_err <= frame_bad;
    end
  end

  // Decoder state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dec_state <= D_NORM;
    else     dec_state <= dec_next;
  end

  // Decoder: E0 prefixes extended keys, F0 marks a release whose code is swallowed.
  always_comb begin
    dec_next  = dec_state;
    push      = 1'b0;
    push_code = rx_byte;
    if (rx_valid) begin
      case (dec_state)
        D_NORM: begin
          if (rx_byte == 8'hE0)      dec_next = D_EXT;
          else if (rx_byte == 8'hF0) dec_next = D_BRK;
          else if (rx_byte != 8'hAA && rx_byte != 8'hFA) push = 1'b1;
        end
        D_EXT: begin
          if (rx_byte == 8'hF0) begin
            dec_next = D_EXTBRK;
          end else begin
            push      = 1'b1;
            push_code = rx_byte | 8'h80;
            dec_next  = D_NORM;
          end
        end
        default: dec_next = D_NORM;
      endcase
    end
  end

  // key_get is registered and edge-detected so a held request pops only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_get_q  <= 1'b0;
      key_get_q2 <= 1'b0;
    end else begin
      key_get_q  <= key_get;
      key_get_q2 <= key_get_q;
    end
  end

  assign pop_req    = key_get_q && !key_get_q2;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign do_pop     = pop_req && !fifo_empty;
  assign do_push    = push && (!fifo_full || do_pop);

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  assign key_down = !fifo_empty;
  assign spec_key = fifo_empty ? 8'h00 : mem[rd_ptr];

endmodule
